// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: sends one {wr, adr[6:0], data} frame MSB-first under cs,
// with programmable setup/hold/gap timing, and shifts miso into rdata on each sclk fall.
module spi_frame_master #(
  parameter int Nbit     = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 8,
  parameter int CS_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wr,
  input  logic [6:0]       adr,
  input  logic [Nbit-1:0]  data,
  output logic             sclk,
  output logic             mosi,
  output logic             cs,
  input  logic             miso,
  output logic [Nbit+7:0]  rdata,
  output logic             busy,
  output logic             done
);

  localparam int FW   = Nbit + 8;
  localparam int BW   = $clog2(Nbit + 9);
  localparam int MAX1 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX2 = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CMAX = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FW - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [BW-1:0]   bit_cnt, bit_nx;
  logic [FW-1:0]   shreg, shreg_nx;
  logic [FW-1:0]   rdata_nx;
  logic            sclk_nx, mosi_nx, cs_nx, busy_nx, done_nx;

  // NOTE: every output is a register, so next values are computed here and
  // committed in one clocked block; defaults first keep this block latch-free.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    rdata_nx = rdata;
    sclk_nx  = sclk;
    mosi_nx  = mosi;
    cs_nx    = cs;
    busy_nx  = busy;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          shreg_nx = {wr, adr, data};
          mosi_nx  = wr;
          cs_nx    = 1'b0;
          busy_nx  = 1'b1;
          bit_nx   = '0;
          state_nx = SETUP;
        end
      end

      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          if (!sclk) begin
            sclk_nx = 1'b1;
          end else begin
            // Falling edge: capture miso, then either advance the bit or finish
            // with mosi left on the last bit.
            sclk_nx  = 1'b0;
            rdata_nx = {rdata[FW-2:0], miso};
            if (bit_cnt == BIT_LAST) begin
              state_nx = HOLD;
            end else begin
              bit_nx   = bit_cnt + BW'(1);
              shreg_nx = shreg << 1;
              mosi_nx  = shreg[FW-2];
            end
          end
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx  = '0;
          cs_nx   = 1'b1;
          mosi_nx = 1'b0;
          if (CS_GAP == 0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            state_nx = GAP;
          end
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rdata   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
      shreg   <= shreg_nx;
      rdata   <= rdata_nx;
      sclk    <= sclk_nx;
      mosi    <= mosi_nx;
      cs      <= cs_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

SPI master that serialises one {write flag, 7-bit address, Nbit data} frame per request onto sclk/mosi/cs. It is the stage directly upstream of the spi_write receiver and drives it on-chip and in testbenches in place of the MCU DMA. Frames are MSB-first, SPI mode 0 (sclk idles low, data sampled on sclk rising edge), exactly Nbit+8 bits with cs held low across the whole frame. The block also captures miso into a read-back register.

## Interface
- Nbit, 8: data field width; frame length is Nbit+8 bits.
- CLK_DIV, 4: clk cycles per sclk half-period (≥1).
- CS_SETUP, 2: clk cycles from cs falling to start of the first sclk low phase (≥1).
- CS_HOLD, 8: clk cycles from the last sclk falling edge to cs rising (≥1). Must cover the receiver's clk-domain capture of ≥6 cycles.
- CS_GAP, 4: clk cycles cs stays high before done (≥0).

- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; accepted only in IDLE.
- wr  in  1  write flag, sent as frame bit Nbit+7 (first bit).
- adr  in  7  address, frame bits Nbit+6..Nbit.
- data  in  Nbit  payload, frame bits Nbit-1..0 (last bits).
- sclk  out  1  SPI clock, registered.
- mosi  out  1  SPI data out, registered.
- cs  out  1  chip select, active low, registered.
- miso  in  1  SPI data in.
- rdata  out  Nbit+8  miso bits of the last frame, MSB first.
- busy  out  1  high from acceptance until frame completion.
- done  out  1  one-cycle pulse at frame completion.

## Operation
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state IDLE.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE. With CS_GAP=0, HOLD goes straight to IDLE.
- IDLE: if start=1, latch {wr,adr,data} into the shift register, drive cs=0 and mosi=wr, set busy=1, and go to SETUP. start is ignored in every other state. It is not queued.
- SETUP: wait CS_SETUP cycles, then go to SHIFT.
- SHIFT, per bit k (Nbit+8 bits total):
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the cycle sclk returns low, sample miso into rdata (shift left) and present the next bit on mosi in the same cycle.
  - After the last high phase, sclk=0 and go to HOLD. mosi holds the last bit.
- Exactly Nbit+8 sclk rising edges per frame. No extra edges ever occur.
- HOLD: cs stays low for CS_HOLD cycles, then cs=1, mosi=0, and go to GAP.
- GAP: wait CS_GAP cycles. On the cycle of return to IDLE: done=1, busy=0. start in that same cycle is accepted, which allows back-to-back frames.
- Bit counter width ≥ clog2(Nbit+9). The divider counter is reloaded on every phase change.
- rdata updates progressively during SHIFT and is final when done pulses.
- Reset mid-frame: outputs return to reset values asynchronously. The receiver sees cs rise with fewer than Nbit+8 edges, so no write occurs.

## Timing
- start sampled at edge T0 → cs=0 and mosi=wr visible after T0.
- First sclk rise at T0+CS_SETUP+CLK_DIV.
- Last sclk fall at T0+CS_SETUP+2·CLK_DIV·(Nbit+8).
- cs rises CS_HOLD cycles after the last sclk fall. done follows CS_GAP cycles after that.
- Frame period: 1+CS_SETUP+2·CLK_DIV·(Nbit+8)+CS_HOLD+CS_GAP cycles. With defaults: 1+2+128+8+4 = 143.
- mosi never changes while sclk=1. cs never changes while sclk=1.

## Test plan
- Loopback into spi_write (Nbit=8, param_adr=1): wr=1, adr=1, data=0xA5 → exactly 16 sclk rises; receiver out=0xA5 with one clr pulse; done after 143 cycles.
- Address mismatch: wr=1, adr=2, data=0x3C → receiver out unchanged (previous 0xA5), no clr. Write flag clear: wr=0, adr=1 → same result.
- start pulsed at cycles 5 and 60 of a frame → ignored; only one frame, one done pulse.
- start held high continuously with data 0x01 then 0x02 → back-to-back frames, cs high for exactly CS_GAP+1 cycles between them, receiver out 0x01 then 0x02.
- miso driven with the pattern 0xF00F → rdata=0xF00F at done.
- rst_n low after 7 sclk rises → cs=1, sclk=0, busy=0 immediately; receiver out unchanged, no clr; a fresh start after reset delivers a correct frame.
